record_play_ctrl: RTL
=====================

// Module: record_play_ctrl
// PURPOSE
//  Record/playback controller sitting directly downstream of the switch-decode stage.
//  Consumes the decoded record/play request levels and sequences a synchronous
//  sample RAM. Recording writes one sample per sample_tick; playback replays the
//  stored take at the same rate. State is exported for the status LEDs.
// PARAMETERS
//  ADDR_W  10  sample RAM address width; capacity = 2**ADDR_W samples
//  DATA_W  8   sample width
// PORTS
//  clk               in   1         system clock, rising edge
//  rst_n             in   1         asynchronous, active-low reset
//  record_req        in   1         record request level, active-high, from switch-decode stage
//  play_req          in   1         play request level, active-high, from switch-decode stage
//  sample_tick       in   1         one-cycle strobe at sample rate
//  sample_in         in   DATA_W    sample to record, valid on sample_tick
//  mem_addr          out  ADDR_W    RAM address
//  mem_we            out  1         RAM write strobe
//  mem_wdata         out  DATA_W    RAM write data
//  mem_re            out  1         RAM read strobe; mem_rdata valid next cycle
//  mem_rdata         in   DATA_W    RAM read data
//  sample_out        out  DATA_W    replayed sample, held between updates
//  sample_out_valid  out  1         one-cycle pulse when sample_out updates
//  state_o           out  2         00 IDLE, 01 RECORD, 10 PLAY
//  rec_len           out  ADDR_W+1  samples in stored take (0..2**ADDR_W)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; wr_ptr/rd_ptr 0; rec_len 0; both re-arm flags set.
//   RAM contents untouched but unreachable (rec_len=0). Reset mid-operation aborts at once.
//  Re-arm: rec_arm cleared on any exit from RECORD, set when record_req=0; play_arm likewise.
//  Transitions (evaluated in IDLE only; other request ignored while active):
//   IDLE->RECORD: record_req=1 & rec_arm. Record wins if both requests high.
//     Entry clears wr_ptr and rec_len (new take overwrites).
//   IDLE->PLAY: play_req=1 & play_arm & rec_len!=0; with rec_len=0, stay IDLE.
//     Entry clears rd_ptr.
//   RECORD->IDLE: record_req=0, or wr_ptr==2**ADDR_W (full).
//   PLAY->IDLE: play_req=0, or the read of address rec_len-1 is issued.
//  Record path: sample_tick in RECORD (not full) -> next cycle mem_we=1,
//   mem_addr=wr_ptr[ADDR_W-1:0], mem_wdata=sample_in captured at tick; wr_ptr+=1 and
//   rec_len=wr_ptr+1 in that cycle. wr_ptr is ADDR_W+1 bits; no wrap.
//  Play path: sample_tick in PLAY -> cycle+1 mem_re=1, mem_addr=rd_ptr, rd_ptr+=1;
//   cycle+2 sample_out=mem_rdata, sample_out_valid=1. Tick-to-valid latency 2 cycles.
//   Read pipeline completes even if state has returned to IDLE (last sample delivered).
//  Exit on request drop: a tick in the same cycle as the drop is ignored; an already-issued
//   write/read still completes.
//  mem_we and mem_re never high together; mem_addr=0 when neither strobe is high.
//  state_o is registered and equals the current state.
// TESTING
//  1 Reset: rst_n=0 mid-RECORD -> state_o=00, rec_len=0, mem_we=0 in the same cycle (async).
//  2 Record 5: record_req=1, 5 ticks with sample_in=0x11..0x55, drop -> writes to addr 0..4,
//     rec_len=5, state_o=00.
//  3 Play 5: play_req=1, ticks -> sample_out 0x11..0x55, each valid 2 cycles after its tick;
//     IDLE after read of addr 4; 6th tick gives no mem_re.
//  4 Full (ADDR_W=3): hold record_req, 10 ticks -> 8 writes, rec_len=8, IDLE; no further
//     RECORD until record_req drops and rises again.
//  5 Both requests rise in the same cycle -> RECORD; play_req ignored until return to IDLE.
//  6 play_req=1 after reset (rec_len=0) -> stays IDLE, no mem_re.

Source files
------------

// File: rtl/record_play_ctrl.sv
// Record/playback sequencer for a synchronous sample RAM.
// Records one sample per sample_tick into RAM, replays the stored take at
// the same rate, and exports its state for the status LEDs.
module record_play_ctrl #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              record_req,
   input  logic              play_req,
   input  logic              sample_tick,
   input  logic [DATA_W-1:0] sample_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_out_valid,
   output logic [1:0]        state_o,
   output logic [ADDR_W:0]   rec_len
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RECORD = 2'b01,
      PLAY   = 2'b10
   } state_t;

   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state;
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic              rec_arm;
   logic              play_arm;
   logic              rd_valid;
   logic [DATA_W-1:0] sample_hold;

   logic wr_go;
   logic rd_go;
   logic rd_last;
   logic rec_exit;
   logic play_exit;

   // Write/read issue and state-exit decisions for the current cycle.
   always_comb begin
      wr_go     = (state == RECORD) && record_req && sample_tick && (wr_ptr != FULL);
      rd_go     = (state == PLAY) && play_req && sample_tick;
      rd_last   = (rd_ptr == (rec_len - ONE));
      rec_exit  = (state == RECORD) && (!record_req || (wr_ptr == FULL));
      play_exit = (state == PLAY) && (!play_req || (rd_go && rd_last));
   end

   // Replay data comes straight from the RAM in its valid cycle and is held afterwards.
   assign sample_out       = rd_valid ? mem_rdata : sample_hold;
   assign sample_out_valid = rd_valid;
   assign state_o          = state;

   // State machine, pointers, re-arm flags and registered RAM strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rec_len     <= '0;
         rec_arm     <= 1'b1;
         play_arm    <= 1'b1;
         rd_valid    <= 1'b0;
         sample_hold <= '0;
         mem_we      <= 1'b0;
         mem_re      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         // A read already issued completes regardless of the state it leaves behind.
         rd_valid  <= mem_re;
         if (rd_valid) sample_hold <= mem_rdata;

         // Releasing a request re-arms it; leaving the mode with the request still held disarms it.
         if (!record_req)    rec_arm  <= 1'b1;
         else if (rec_exit)  rec_arm  <= 1'b0;
         if (!play_req)      play_arm <= 1'b1;
         else if (play_exit) play_arm <= 1'b0;

         case (state)
            IDLE: begin
               if (record_req && rec_arm) begin
                  state   <= RECORD;
                  wr_ptr  <= '0;
                  rec_len <= '0;
               end else if (play_req && play_arm && (rec_len != '0)) begin
                  state  <= PLAY;
                  rd_ptr <= '0;
               end
            end
            RECORD: begin
               if (rec_exit) begin
                  state <= IDLE;
               end else if (wr_go) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= wr_ptr[ADDR_W-1:0];
                  mem_wdata <= sample_in;
                  wr_ptr    <= wr_ptr + ONE;
                  rec_len   <= wr_ptr + ONE;
               end
            end
            PLAY: begin
               if (rd_go) begin
                  mem_re   <= 1'b1;
                  mem_addr <= rd_ptr[ADDR_W-1:0];
                  rd_ptr   <= rd_ptr + ONE;
               end
               if (play_exit) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
